// File: rtl/charlie_pwm.sv
// Charlieplexed LED matrix driver with per-LED PWM brightness and a Wishbone classic frame-buffer port.
// Optional macro CHARLIE_DOUBLE_BUFFER_EN adds front/back buffers swapped at frame wrap.
module charlie_pwm #(
  parameter int PINS           = 7,
  parameter int BITS           = 4,
  parameter int ADDR_W         = 6,
  parameter int TICKS_PER_STEP = 64,
  parameter int DEAD_TICKS     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [BITS-1:0]   wb_dat_i,
  output logic [BITS-1:0]   wb_dat_o,
  output logic              wb_ack_o,
  output logic [PINS-1:0]   charlie_oe,
  output logic [PINS-1:0]   charlie_o,
  output logic              frame_sync
);

  localparam int LEDS   = PINS * (PINS - 1);
  localparam int IDX_W  = $clog2(LEDS);
  localparam int ROW_W  = (PINS > 2) ? $clog2(PINS) : 1;
  localparam int PS_W   = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(TICKS_PER_STEP - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);
  localparam logic [BITS-1:0]   PWM_LAST  = BITS'((2 ** BITS) - 2);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(PINS - 1);
  localparam logic [ADDR_W-1:0] LEDS_ADR  = ADDR_W'(LEDS);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t            state;
  logic [ROW_W-1:0]  row;
  logic [DEAD_W-1:0] dead_cnt;
  logic [PS_W-1:0]   presc;
  logic [BITS-1:0]   pwm;

  logic [BITS-1:0] level_a [LEDS];
`ifdef CHARLIE_DOUBLE_BUFFER_EN
  logic [BITS-1:0] level_b [LEDS];
  logic            front_sel;
  logic            swap_pending;
`endif

  logic            wb_req;
  logic            in_range;
  logic [IDX_W-1:0] wb_idx;

  assign wb_req   = wb_stb_i && !wb_ack_o;
  assign in_range = wb_adr_i < LEDS_ADR;
  assign wb_idx   = wb_adr_i[IDX_W-1:0];

  // Scan decode: anode on the row pin, cathode enabled on each column still inside its PWM window.
  logic [PINS-1:0]  next_oe;
  logic [PINS-1:0]  next_o;
  logic [IDX_W-1:0] scan_idx;
  logic [BITS-1:0]  scan_level;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    next_oe    = '0;
    next_o     = '0;
    scan_idx   = '0;
    scan_level = '0;
    if (state == DRIVE) begin
      for (int c = 0; c < PINS; c++) begin
        if (c == int'(row)) begin
          next_oe[c] = 1'b1;
          next_o[c]  = 1'b1;
        end else begin
          scan_idx = IDX_W'(int'(row) * (PINS - 1) + ((c < int'(row)) ? c : c - 1));
`ifdef CHARLIE_DOUBLE_BUFFER_EN
          scan_level = front_sel ? level_b[scan_idx] : level_a[scan_idx];
`else
          scan_level = level_a[scan_idx];
`endif
          next_oe[c] = scan_level > pwm;
        end
      end
    end
  end

  // Scanner FSM with registered pin outputs; frame_sync rises together with the row-0 BLANK entry.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state      <= BLANK;
      row        <= '0;
      dead_cnt   <= '0;
      presc      <= '0;
      pwm        <= '0;
      frame_sync <= 1'b0;
      charlie_oe <= '0;
      charlie_o  <= '0;
    end else begin
      charlie_oe <= next_oe;
      charlie_o  <= next_o;
      frame_sync <= 1'b0;
      case (state)
        BLANK: begin
          if (dead_cnt == DEAD_LAST) begin
            dead_cnt <= '0;
            presc    <= '0;
            pwm      <= '0;
            state    <= DRIVE;
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (presc == PS_LAST) begin
            presc <= '0;
            if (pwm == PWM_LAST) begin
              state <= BLANK;
              if (row == ROW_LAST) begin
                row        <= '0;
                frame_sync <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              pwm <= pwm + 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

  // Wishbone handshake: one-clock ack per request, read data registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
`ifdef CHARLIE_DOUBLE_BUFFER_EN
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
`endif
    end else begin
      wb_ack_o <= wb_req;
      if (wb_req) begin
        if (!in_range) begin
          wb_dat_o <= '0;
        end else begin
`ifdef CHARLIE_DOUBLE_BUFFER_EN
          wb_dat_o <= front_sel ? level_a[wb_idx] : level_b[wb_idx];
`else
          wb_dat_o <= level_a[wb_idx];
`endif
        end
      end
`ifdef CHARLIE_DOUBLE_BUFFER_EN
      // A request landing on the frame_sync clock itself re-arms for the following wrap.
      if (frame_sync && swap_pending) front_sel <= ~front_sel;
      if (wb_req && wb_we_i && wb_adr_i == LEDS_ADR) swap_pending <= 1'b1;
      else if (frame_sync)                            swap_pending <= 1'b0;
`endif
    end
  end

  // NOTE: the frame buffer is deliberately not reset; it is plain storage defined by its first write.
  always_ff @(posedge clk) begin
    if (wb_req && wb_we_i && in_range) begin
`ifdef CHARLIE_DOUBLE_BUFFER_EN
      if (front_sel) level_a[wb_idx] <= wb_dat_i;
      else           level_b[wb_idx] <= wb_dat_i;
`else
      level_a[wb_idx] <= wb_dat_i;
`endif
    end
  end

endmodule

// File: tb/tb_charlie_pwm.sv
// Directed self-checking bench for charlie_pwm at PINS=3, BITS=2, one clock per PWM step, one dead clock.
module tb_charlie_pwm;

  localparam int PINS = 3;
  localparam int BITS = 2;
  localparam int ADDR_W = 4;
  localparam int LEDS = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wb_stb_i = 1'b0;
  logic              wb_we_i = 1'b0;
  logic [ADDR_W-1:0] wb_adr_i = '0;
  logic [BITS-1:0]   wb_dat_i = '0;
  logic [BITS-1:0]   wb_dat_o;
  logic              wb_ack_o;
  logic [PINS-1:0]   charlie_oe;
  logic [PINS-1:0]   charlie_o;
  logic              frame_sync;

  int errors = 0;
  int checks = 0;
  logic [BITS-1:0] model [LEDS];

  charlie_pwm #(
    .PINS(PINS), .BITS(BITS), .ADDR_W(ADDR_W), .TICKS_PER_STEP(1), .DEAD_TICKS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .charlie_oe(charlie_oe), .charlie_o(charlie_o), .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [ADDR_W-1:0] adr, input logic [BITS-1:0] dat, output logic acked);
    wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = dat;
    step();
    acked = wb_ack_o;
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    step();
  endtask

  task automatic wb_read(input logic [ADDR_W-1:0] adr, output logic [BITS-1:0] dat, output logic acked);
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    step();
    acked = wb_ack_o;
    dat = wb_dat_o;
    wb_stb_i = 1'b0;
    step();
  endtask

  task automatic wait_sync(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame_sync) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_frame_sync: got no pulse in 40 clocks, expected one within 12");
    end
  endtask

  // Writes one LED so that the scanned image holds it (both buffers when double buffered).
  task automatic write_led(input int idx, input logic [BITS-1:0] val);
    logic a;
    logic ok;
    wb_write(ADDR_W'(idx), val, a);
`ifdef CHARLIE_DOUBLE_BUFFER_EN
    wb_write(ADDR_W'(LEDS), '0, a);
    wait_sync(ok);
    step();
    wb_write(ADDR_W'(idx), val, a);
`endif
    checks++;
    if (a !== 1'b1) begin
      errors++;
      $display("FAIL write_led_ack idx=%0d: got %b expected 1", idx, a);
    end
    model[idx] = val;
  endtask

  function automatic logic [PINS-1:0] exp_oe(input int r, input int p);
    logic [PINS-1:0] v;
    int idx;
    v = '0;
    v[r] = 1'b1;
    for (int c = 0; c < PINS; c++) begin
      if (c != r) begin
        idx = r * (PINS - 1) + ((c < r) ? c : c - 1);
        if (int'(model[idx]) > p) v[c] = 1'b1;
      end
    end
    return v;
  endfunction

  // Called right after a frame_sync sample; compares the next full frame clock by clock.
  task automatic scan_frame(input string name);
    logic [PINS-1:0] e_oe, e_o;
    int row, pos;
    for (int k = 1; k <= 12; k++) begin
      step();
      row = (k - 1) / 4;
      pos = (k - 1) % 4;
      if (pos == 0) begin
        e_oe = '0; e_o = '0;
      end else begin
        e_oe = exp_oe(row, pos - 1);
        e_o = '0;
        e_o[row] = 1'b1;
      end
      checks++;
      if (charlie_oe !== e_oe || charlie_o !== e_o || frame_sync !== (k == 12)) begin
        errors++;
        $display("FAIL %s clk=%0d: oe=%b o=%b sync=%b expected oe=%b o=%b sync=%b",
                 name, k, charlie_oe, charlie_o, frame_sync, e_oe, e_o, (k == 12));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (charlie_oe !== '0 || charlie_o !== '0 || wb_ack_o !== 1'b0 || wb_dat_o !== '0 || frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: oe=%b o=%b ack=%b dat=%0d sync=%b expected all 0",
               charlie_oe, charlie_o, wb_ack_o, wb_dat_o, frame_sync);
    end
    rst_n = 1'b1;
    for (int i = 0; i < LEDS; i++) write_led(i, '0);
  endtask

  task automatic test_reset_mid_scan();
    logic ok;
    wait_sync(ok);
    step();
    step();
    checks++;
    if (charlie_oe !== 3'b001) begin
      errors++;
      $display("FAIL pre_reset_drive: oe=%b expected 001", charlie_oe);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (charlie_oe !== '0 || charlie_o !== '0) begin
      errors++;
      $display("FAIL async_reset_hiz: oe=%b o=%b expected 000 000", charlie_oe, charlie_o);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (charlie_oe !== '0) begin
      errors++;
      $display("FAIL post_reset_blank: oe=%b expected 000", charlie_oe);
    end
    step();
    checks++;
    if (charlie_oe !== 3'b001 || charlie_o !== 3'b001) begin
      errors++;
      $display("FAIL post_reset_row0: oe=%b o=%b expected 001 001", charlie_oe, charlie_o);
    end
  endtask

  task automatic test_row0_level();
    logic ok;
    write_led(0, 2'd3);
    wait_sync(ok);
    scan_frame("row0_level3");
  endtask

  task automatic test_row1_level();
    logic ok;
    write_led(3, 2'd1);
    wait_sync(ok);
    scan_frame("row1_level1");
    scan_frame("row1_level1_next");
  endtask

  task automatic test_wishbone();
    logic a;
    logic [BITS-1:0] d;
    wb_write(4'd5, 2'd2, a);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL wb_write_ack: got %b expected 1", a); end
    wb_read(4'd5, d, a);
    checks++;
    if (a !== 1'b1 || d !== 2'd2) begin
      errors++; $display("FAIL wb_read_adr5: ack=%b dat=%0d expected ack=1 dat=2", a, d);
    end
    wb_read(4'd9, d, a);
    checks++;
    if (a !== 1'b1 || d !== 2'd0) begin
      errors++; $display("FAIL wb_read_adr9: ack=%b dat=%0d expected ack=1 dat=0", a, d);
    end
`ifndef CHARLIE_DOUBLE_BUFFER_EN
    wb_write(4'd6, 2'd3, a);
    wb_read(4'd6, d, a);
    checks++;
    if (a !== 1'b1 || d !== 2'd0) begin
      errors++; $display("FAIL wb_adr6_ignored: ack=%b dat=%0d expected ack=1 dat=0", a, d);
    end
`endif
    write_led(5, 2'd2);
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'd5;
    seen[3] = wb_ack_o;
    for (int i = 2; i >= 0; i--) begin
      step();
      seen[i] = wb_ack_o;
    end
    wb_stb_i = 1'b0;
    checks++;
    if (seen !== 4'b0101 || wb_dat_o !== 2'd2) begin
      errors++; $display("FAIL back_to_back_ack: pattern=%b dat=%0d expected 0101 dat=2", seen, wb_dat_o);
    end
    step();
  endtask

  task automatic test_blanking();
    logic ok;
    int double_hi, hiz, run, max_run;
    double_hi = 0; hiz = 0; run = 0; max_run = 0;
    wait_sync(ok);
    for (int k = 0; k < 36; k++) begin
      step();
      if ($countones(charlie_oe & charlie_o) > 1) double_hi++;
      if (charlie_oe == '0) begin
        hiz++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    checks++;
    if (double_hi !== 0) begin errors++; $display("FAIL two_pins_high: got %0d clocks expected 0", double_hi); end
    checks++;
    if (hiz !== 9) begin errors++; $display("FAIL hiz_clocks: got %0d expected 9", hiz); end
    checks++;
    if (max_run !== 1) begin errors++; $display("FAIL hiz_run: got %0d expected 1", max_run); end
  endtask

`ifdef CHARLIE_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    logic a, ok;
    logic [BITS-1:0] d;
    int lit_before, lit_after;
    lit_before = 0; lit_after = 0; ok = 1'b0;
    write_led(0, '0);
    wb_write(4'd0, 2'd3, a);
    wb_write(ADDR_W'(LEDS), '0, a);
    for (int i = 0; i < 40; i++) begin
      step();
      if (charlie_oe == 3'b011) lit_before++;
      if (frame_sync) begin ok = 1'b1; break; end
    end
    for (int k = 0; k < 12; k++) begin
      step();
      if (charlie_oe == 3'b011) lit_after++;
    end
    checks++;
    if (!ok || lit_before !== 0 || lit_after !== 3) begin
      errors++;
      $display("FAIL swap_timing: sync=%b lit_before=%0d lit_after=%0d expected 1 0 3", ok, lit_before, lit_after);
    end
    model[0] = 2'd3;
    wb_read(4'd0, d, a);
    checks++;
    if (d !== 2'd0) begin errors++; $display("FAIL swap_readback: got %0d expected 0", d); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_scan();
    test_row0_level();
    test_row1_level();
    test_wishbone();
    test_back_to_back();
    test_blanking();
`ifdef CHARLIE_DOUBLE_BUFFER_EN
    test_double_buffer();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
